hcu_scoreboard: RTL and testbench
=================================

// Module: hcu_scoreboard
// PURPOSE
//  Parametrised hazard control unit. Adds a per-register latency scoreboard for multi-cycle loads and MDU ops,
//  and an N-stage forwarding priority mux. Handles a single-MDU structural hazard and a multi-cycle redirect flush.
//  Sits beside the pipeline and drives its stall/flush/forward controls, issuing at the Decode->Execute boundary.
// PARAMETERS
//  NUM_REGS      32  architectural registers; x0 never tracked
//  RW            5   register index width, = $clog2(NUM_REGS)
//  FWD_STAGES    2   forwarding sources after E; stage 1 = youngest
//  LOAD_LAT      2   cycles from load issue until its result sits in a forwarding stage
//  MDU_LAT       4   cycles from MDU issue until its result sits in a forwarding stage
//  REDIRECT_LAT  1   cycles FlushD stays high after a misprediction
// PORTS
//  clk           in  1                         clock, rising edge
//  reset         in  1                         synchronous, active-high
//  A1_E, A2_E    in  RW                        source registers of the instruction in Execute
//  rd_E          in  RW                        destination register of the instruction in Execute
//  RegWE_E       in  1                         instruction in Execute writes rd_E
//  kind_E        in  2                         hcu_pkg::kind_e: ALU=0, LOAD=1, MDU=2
//  ex_fire_E     in  1                         instruction in Execute leaves E this cycle (pipeline computes it as valid & !StallE)
//  fwd_rd        in  FWD_STAGES*RW             destination register per forwarding stage
//  fwd_we        in  FWD_STAGES                write-enable per forwarding stage
//  branch_D      in  1                         conditional branch in Decode
//  jump_D        in  1                         jump in Decode
//  branch_E      in  1                         branch in Execute
//  condition_met_E in 1                        branch condition met in Execute
//  StallF, StallD, StallE  out 1               hold the stage register
//  FlushD, FlushE          out 1               bubble the stage register
//  BubbleE       out 1                         E result invalid this cycle; downstream latches a NOP
//  fwdA_E, fwdB_E out $clog2(FWD_STAGES+1)     0 = register file, k = forwarding stage k
//  sb_busy       out NUM_REGS                  per-register pending flag, i.e. cnt!=0
// BEHAVIOUR
//  - Reset: all scoreboard counters, mdu_cnt and redir_cnt are cleared; every output is 0. A reset mid-operation
//    discards all pending writes.
//  - Scoreboard: cnt[r] is $clog2(max(LOAD_LAT,MDU_LAT)+1) bits wide. Each cycle every nonzero cnt decrements by 1.
//    * On ex_fire_E && RegWE_E && rd_E!=0, cnt[rd_E] loads LOAD_LAT (LOAD), MDU_LAT (MDU) or 0 (ALU).
//    * Load has priority over decrement for the same register.
//  - Forwarding (combinational): for each operand, pick the lowest k with fwd_we[k] && fwd_rd[k]==A && A!=0;
//    otherwise select 0. This rule applies even while stalled.
//  - data_haz = (A1_E!=0 && cnt[A1_E]!=0) || (A2_E!=0 && cnt[A2_E]!=0).
//  - mdu_cnt loads MDU_LAT when an MDU op fires and decrements to 0.
//    struct_haz = kind_E==MDU && mdu_cnt>1, so back-to-back issue is legal on the final cycle.
//  - Priority, highest first; every output is assigned on every path:
//    1 mispredict = branch_E && !condition_met_E: FlushD=FlushE=1, all stalls 0, redir_cnt <= REDIRECT_LAT-1.
//    2 redir_cnt!=0: FlushD=1, redir_cnt decrements.
//    3 data_haz || struct_haz: StallF=StallD=StallE=1, BubbleE=1, no flushes. The scoreboard keeps decrementing,
//      so the stall length equals the remaining count.
//    4 (branch_D||jump_D): FlushD=1.
//    5 otherwise all 0.
//  - A mispredict during a data stall flushes E. The flushed instruction never fires, so the scoreboard gets no entry.
//  - WAW: a newer write to a busy register overwrites its counter. A younger ALU write sets 0, and forwarding
//    resolves it by priority.
// STRUCTURE
//  - hcu_pkg holds: kind_e enum, FWD_SEL_W function, default latency constants.
//  - One sub-module, hcu_fwd_sel (parametrised over FWD_STAGES), instantiated once per operand.
//  - The scoreboard is an inline generate loop over registers 1..NUM_REGS-1.
// TESTING
//  1 Reset held 3 cycles with all inputs at 1 -> all outputs 0, sb_busy=0.
//  2 LOAD rd=5 fires, next instr A1_E=5 -> StallF/D/E=BubbleE=1 for 2 cycles.
//    Then fwd_rd[1]=5, fwd_we=1 -> fwdA_E=1, no stall.
//  3 MDU rd=7 fires, second MDU follows -> stall 3 cycles (mdu_cnt 4..2) and issue on cycle 4.
//    A2_E=7 in the same instruction -> stall is 4 cycles.
//  4 fwd_rd={7,7}, fwd_we=2'b11, A1_E=7 -> fwdA_E=1 (youngest). A1_E=0 -> fwdA_E=0.
//  5 REDIRECT_LAT=3, branch_E=1, condition_met_E=0, with data_haz also set -> FlushD 3 cycles, FlushE 1 cycle,
//    stalls 0 in cycle 1.
//  6 LOAD rd=5 pending (cnt=2) and reset asserted -> next cycle sb_busy[5]=0; A1_E=5 -> no stall.

Source files
------------

// File: rtl/hcu_pkg.sv
// Shared types and defaults for the hazard control unit.
package hcu_pkg;

  typedef enum logic [1:0] {
    KindAlu  = 2'd0,
    KindLoad = 2'd1,
    KindMdu  = 2'd2
  } kind_e;

  localparam int unsigned DefNumRegs     = 32;
  localparam int unsigned DefFwdStages   = 2;
  localparam int unsigned DefLoadLat     = 2;
  localparam int unsigned DefMduLat      = 4;
  localparam int unsigned DefRedirectLat = 1;

  // Width of a forwarding select: 0 = register file, 1..stages = forwarding stage.
  function automatic int unsigned FWD_SEL_W(input int unsigned stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hcu_fwd_sel.sv
// Forwarding priority mux for one source operand: lowest (youngest) matching stage wins.
module hcu_fwd_sel
  import hcu_pkg::*;
#(
  parameter int unsigned FWD_STAGES = DefFwdStages,
  parameter int unsigned RW         = 5
) (
  input  logic [RW-1:0]                    src_i,
  input  logic [FWD_STAGES*RW-1:0]         fwd_rd_i,
  input  logic [FWD_STAGES-1:0]            fwd_we_i,
  output logic [FWD_SEL_W(FWD_STAGES)-1:0] sel_o
);

  localparam int unsigned SelW = FWD_SEL_W(FWD_STAGES);

  always_comb begin
    sel_o = '0;
    if (src_i != '0) begin
      // Walk oldest to youngest so the youngest match is the last one written.
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (fwd_we_i[k-1] && (fwd_rd_i[(k-1)*RW +: RW] == src_i)) begin
          sel_o = SelW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hcu_scoreboard.sv
// Hazard control unit: per-register latency scoreboard, MDU structural hazard,
// redirect flush sequencing and operand forwarding selects.
module hcu_scoreboard
  import hcu_pkg::*;
#(
  parameter int unsigned NUM_REGS     = DefNumRegs,
  parameter int unsigned RW           = $clog2(NUM_REGS),
  parameter int unsigned FWD_STAGES   = DefFwdStages,
  parameter int unsigned LOAD_LAT     = DefLoadLat,
  parameter int unsigned MDU_LAT      = DefMduLat,
  parameter int unsigned REDIRECT_LAT = DefRedirectLat
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [RW-1:0]                    A1_E,
  input  logic [RW-1:0]                    A2_E,
  input  logic [RW-1:0]                    rd_E,
  input  logic                             RegWE_E,
  input  logic [1:0]                       kind_E,
  input  logic                             ex_fire_E,
  input  logic [FWD_STAGES*RW-1:0]         fwd_rd,
  input  logic [FWD_STAGES-1:0]            fwd_we,
  input  logic                             branch_D,
  input  logic                             jump_D,
  input  logic                             branch_E,
  input  logic                             condition_met_E,
  output logic                             StallF,
  output logic                             StallD,
  output logic                             StallE,
  output logic                             FlushD,
  output logic                             FlushE,
  output logic                             BubbleE,
  output logic [FWD_SEL_W(FWD_STAGES)-1:0] fwdA_E,
  output logic [FWD_SEL_W(FWD_STAGES)-1:0] fwdB_E,
  output logic [NUM_REGS-1:0]              sb_busy
);

  localparam int unsigned MaxLat = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);
  localparam int unsigned MduW   = $clog2(MDU_LAT + 1);
  localparam int unsigned RedW   = (REDIRECT_LAT > 1) ? $clog2(REDIRECT_LAT) : 1;
  localparam int unsigned SelW   = FWD_SEL_W(FWD_STAGES);

  kind_e               kind;
  logic                sb_wr;
  logic [CntW-1:0]     wr_lat;
  logic [NUM_REGS-1:0] busy;

  assign kind  = kind_e'(kind_E);
  assign sb_wr = ex_fire_E && RegWE_E && (rd_E != '0);

  always_comb begin
    case (kind)
      KindLoad: wr_lat = CntW'(LOAD_LAT);
      KindMdu:  wr_lat = CntW'(MDU_LAT);
      default:  wr_lat = '0;
    endcase
  end

  // Scoreboard: x0 is never tracked.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (sb_wr && (rd_E == RW'(r))) begin
        cnt_d = wr_lat;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy[r] = (cnt_q != '0);
  end

  // Single MDU: a new MDU op may issue once only the final cycle remains.
  logic [MduW-1:0] mdu_cnt_d, mdu_cnt_q;

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (ex_fire_E && (kind == KindMdu)) begin
      mdu_cnt_d = MduW'(MDU_LAT);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - MduW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_cnt_q <= '0;
    end else begin
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  logic mispredict, data_haz, struct_haz;

  assign mispredict = branch_E && !condition_met_E;
  assign data_haz   = ((A1_E != '0) && busy[A1_E]) || ((A2_E != '0) && busy[A2_E]);
  assign struct_haz = (kind == KindMdu) && (mdu_cnt_q > MduW'(1));

  logic [RedW-1:0] redir_cnt_d, redir_cnt_q;
  logic            stall, flush_d, flush_e;

  always_comb begin
    stall       = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    redir_cnt_d = redir_cnt_q;
    if (mispredict) begin
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      redir_cnt_d = RedW'(REDIRECT_LAT - 1);
    end else if (redir_cnt_q != '0) begin
      flush_d     = 1'b1;
      redir_cnt_d = redir_cnt_q - RedW'(1);
    end else if (data_haz || struct_haz) begin
      stall = 1'b1;
    end else if (branch_D || jump_D) begin
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redir_cnt_q <= '0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
    end
  end

  logic [SelW-1:0] sel_a, sel_b;

  hcu_fwd_sel #(
    .FWD_STAGES (FWD_STAGES),
    .RW         (RW)
  ) u_fwd_a (
    .src_i    (A1_E),
    .fwd_rd_i (fwd_rd),
    .fwd_we_i (fwd_we),
    .sel_o    (sel_a)
  );

  hcu_fwd_sel #(
    .FWD_STAGES (FWD_STAGES),
    .RW         (RW)
  ) u_fwd_b (
    .src_i    (A2_E),
    .fwd_rd_i (fwd_rd),
    .fwd_we_i (fwd_we),
    .sel_o    (sel_b)
  );

  // While reset is held every output is forced quiet, whatever the inputs say.
  assign StallF  = !reset && stall;
  assign StallD  = !reset && stall;
  assign StallE  = !reset && stall;
  assign BubbleE = !reset && stall;
  assign FlushD  = !reset && flush_d;
  assign FlushE  = !reset && flush_e;
  assign fwdA_E  = reset ? '0 : sel_a;
  assign fwdB_E  = reset ? '0 : sel_b;
  assign sb_busy = reset ? '0 : busy;

endmodule

// File: tb/tb_hcu_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-time reference model.
module tb_hcu_scoreboard;
  import hcu_pkg::*;

  localparam int unsigned NR  = 32;
  localparam int unsigned RWL = 5;
  localparam int unsigned FS  = 2;
  localparam int unsigned LL  = 2;
  localparam int unsigned ML  = 4;
  localparam int unsigned RL  = 3;
  localparam int unsigned SW  = FWD_SEL_W(FS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [RWL-1:0] A1_E, A2_E, rd_E;
  logic           RegWE_E, ex_fire_E;
  logic [1:0]     kind_E;
  logic [FS*RWL-1:0] fwd_rd;
  logic [FS-1:0]  fwd_we;
  logic           branch_D, jump_D, branch_E, condition_met_E;
  logic           StallF, StallD, StallE, FlushD, FlushE, BubbleE;
  logic [SW-1:0]  fwdA_E, fwdB_E;
  logic [NR-1:0]  sb_busy;

  hcu_scoreboard #(
    .NUM_REGS     (NR),
    .RW           (RWL),
    .FWD_STAGES   (FS),
    .LOAD_LAT     (LL),
    .MDU_LAT      (ML),
    .REDIRECT_LAT (RL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .A1_E            (A1_E),
    .A2_E            (A2_E),
    .rd_E            (rd_E),
    .RegWE_E         (RegWE_E),
    .kind_E          (kind_E),
    .ex_fire_E       (ex_fire_E),
    .fwd_rd          (fwd_rd),
    .fwd_we          (fwd_we),
    .branch_D        (branch_D),
    .jump_D          (jump_D),
    .branch_E        (branch_E),
    .condition_met_E (condition_met_E),
    .StallF          (StallF),
    .StallD          (StallD),
    .StallE          (StallE),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .BubbleE         (BubbleE),
    .fwdA_E          (fwdA_E),
    .fwdB_E          (fwdB_E),
    .sb_busy         (sb_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 1;

  // Reference state as absolute cycle numbers: a register is pending while cyc < ready_at.
  int ready_at [NR];
  int mdu_until   = 0;
  int redir_until = 0;
  logic valid;

  logic [5:0]    e_ctl;  // {StallF, StallD, StallE, FlushD, FlushE, BubbleE}
  logic [SW-1:0] e_fa, e_fb;
  logic [NR-1:0] e_busy;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] fwd_pick(input logic [RWL-1:0] a);
    if (a == '0) return '0;
    for (int k = 1; k <= int'(FS); k++) begin
      if (fwd_we[k-1] && fwd_rd[(k-1)*RWL +: RWL] == a) return SW'(k);
    end
    return '0;
  endfunction

  task automatic model_eval();
    logic mis, dh, sh;
    e_ctl  = '0;
    e_fa   = '0;
    e_fb   = '0;
    e_busy = '0;
    if (!reset) begin
      for (int r = 1; r < int'(NR); r++) e_busy[r] = (cyc < ready_at[r]);
      mis = branch_E && !condition_met_E;
      dh  = (A1_E != 0 && e_busy[A1_E]) || (A2_E != 0 && e_busy[A2_E]);
      sh  = (kind_E == 2'd2) && (cyc < mdu_until);
      if (mis)                     e_ctl = 6'b000110;
      else if (cyc < redir_until)  e_ctl = 6'b000100;
      else if (dh || sh)           e_ctl = 6'b111001;
      else if (branch_D || jump_D) e_ctl = 6'b000100;
      e_fa = fwd_pick(A1_E);
      e_fb = fwd_pick(A2_E);
    end
  endtask

  task automatic model_update();
    int lat;
    if (reset) begin
      for (int r = 0; r < int'(NR); r++) ready_at[r] = 0;
      mdu_until   = 0;
      redir_until = 0;
    end else begin
      if (branch_E && !condition_met_E) redir_until = cyc + int'(RL);
      lat = (kind_E == 2'd1) ? int'(LL) : (kind_E == 2'd2) ? int'(ML) : 0;
      if (ex_fire_E && RegWE_E && rd_E != 0) ready_at[rd_E] = cyc + 1 + lat;
      if (ex_fire_E && kind_E == 2'd2) mdu_until = cyc + int'(ML);
    end
  endtask

  // First half of a cycle: derive the fire strobe as the pipeline would, then compare.
  task automatic eval_cycle();
    model_eval();
    ex_fire_E = valid && !e_ctl[3];
    #1;
    check_eq("ctl", 64'({StallF, StallD, StallE, FlushD, FlushE, BubbleE}), 64'(e_ctl));
    check_eq("fwdA", 64'(fwdA_E), 64'(e_fa));
    check_eq("fwdB", 64'(fwdB_E), 64'(e_fb));
    check_eq("busy", 64'(sb_busy), 64'(e_busy));
  endtask

  task automatic end_cycle();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    eval_cycle();
    end_cycle();
  endtask

  task automatic set_idle();
    reset = 1'b0; valid = 1'b0; A1_E = '0; A2_E = '0; rd_E = '0; RegWE_E = 1'b0;
    kind_E = 2'd0; fwd_rd = '0; fwd_we = '0; branch_D = 1'b0; jump_D = 1'b0;
    branch_E = 1'b0; condition_met_E = 1'b0;
  endtask

  task automatic issue(input logic [1:0] k, input logic [RWL-1:0] rd,
                       input logic [RWL-1:0] a1, input logic [RWL-1:0] a2);
    valid = 1'b1; kind_E = k; rd_E = rd; RegWE_E = 1'b1; A1_E = a1; A2_E = a2;
  endtask

  initial begin
    for (int r = 0; r < int'(NR); r++) ready_at[r] = 0;
    set_idle();
    ex_fire_E = 1'b0;
    @(posedge clk);
    #1;

    // Reset with every input high.
    reset = 1'b1; valid = 1'b1; A1_E = '1; A2_E = '1; rd_E = '1; RegWE_E = 1'b1;
    kind_E = 2'b11; fwd_rd = '1; fwd_we = '1; branch_D = 1'b1; jump_D = 1'b1;
    branch_E = 1'b1; condition_met_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      check_eq("rst_out", 64'({StallF, StallD, StallE, FlushD, FlushE, BubbleE, fwdA_E, fwdB_E}),
               64'(0));
      end_cycle();
    end
    set_idle();
    tick();

    // Load-use: two stall cycles, then forwarding from stage 1.
    issue(2'd1, 5'd5, 5'd0, 5'd0);
    tick();
    issue(2'd0, 5'd6, 5'd5, 5'd0);
    for (int i = 0; i < 2; i++) begin
      eval_cycle();
      check_eq("ld_stall", 64'(StallE && BubbleE && StallF), 64'(1));
      end_cycle();
    end
    fwd_rd = {5'd0, 5'd5}; fwd_we = 2'b01;
    eval_cycle();
    check_eq("ld_fwd", 64'({StallE, fwdA_E}), 64'(1));
    end_cycle();
    set_idle();
    tick();

    // Back-to-back MDU: structural stall of 3 cycles.
    issue(2'd2, 5'd7, 5'd0, 5'd0);
    tick();
    issue(2'd2, 5'd8, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      check_eq("mdu_struct", 64'(StallE), 64'(i < 3));
      end_cycle();
    end
    set_idle();
    repeat (5) tick();

    // Dependent MDU: data hazard dominates, 4 stall cycles.
    issue(2'd2, 5'd7, 5'd0, 5'd0);
    tick();
    issue(2'd2, 5'd9, 5'd0, 5'd7);
    for (int i = 0; i < 5; i++) begin
      eval_cycle();
      check_eq("mdu_data", 64'(StallE), 64'(i < 4));
      end_cycle();
    end
    set_idle();
    repeat (5) tick();

    // Forwarding priority: youngest stage wins, x0 never forwards.
    fwd_rd = {5'd7, 5'd7}; fwd_we = 2'b11; A1_E = 5'd7;
    eval_cycle();
    check_eq("fwd_young", 64'(fwdA_E), 64'(1));
    end_cycle();
    A1_E = 5'd0;
    eval_cycle();
    check_eq("fwd_x0", 64'(fwdA_E), 64'(0));
    end_cycle();
    fwd_rd = {5'd3, 5'd4}; fwd_we = 2'b11; A2_E = 5'd3;
    eval_cycle();
    check_eq("fwd_old", 64'(fwdB_E), 64'(2));
    end_cycle();
    set_idle();

    // Mispredict over a data hazard: FlushD for RL cycles, FlushE once.
    issue(2'd1, 5'd9, 5'd0, 5'd0);
    tick();
    valid = 1'b1; RegWE_E = 1'b0; kind_E = 2'd0; A1_E = 5'd9; branch_E = 1'b1;
    condition_met_E = 1'b0;
    eval_cycle();
    check_eq("mis_c1", 64'({FlushD, FlushE, StallE}), 64'(3'b110));
    end_cycle();
    branch_E = 1'b0;
    for (int i = 1; i < 4; i++) begin
      eval_cycle();
      check_eq("mis_redir", 64'({FlushD, FlushE}), 64'((i < int'(RL)) ? 2'b10 : 2'b00));
      end_cycle();
    end
    set_idle();
    repeat (3) tick();

    // Reset discards a pending load.
    issue(2'd1, 5'd5, 5'd0, 5'd0);
    tick();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0; valid = 1'b1; A1_E = 5'd5;
    eval_cycle();
    check_eq("rst_drop", 64'({StallE, sb_busy[5]}), 64'(0));
    end_cycle();
    set_idle();

    // Random traffic on a small register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      valid           = ($urandom_range(0, 3) != 0);
      A1_E            = RWL'($urandom_range(0, 7));
      A2_E            = RWL'($urandom_range(0, 7));
      rd_E            = RWL'($urandom_range(0, 7));
      RegWE_E         = ($urandom_range(0, 3) != 0);
      kind_E          = 2'($urandom_range(0, 2));
      for (int k = 0; k < int'(FS); k++) fwd_rd[k*RWL +: RWL] = RWL'($urandom_range(0, 7));
      fwd_we          = FS'($urandom);
      branch_D        = ($urandom_range(0, 7) == 0);
      jump_D          = ($urandom_range(0, 9) == 0);
      branch_E        = ($urandom_range(0, 7) == 0);
      condition_met_E = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
